// File: rtl/binary_to_bcd.sv
// Binary to two-digit BCD converter using unrolled double-dabble, with overflow saturation.
// Define BCD_REG_OUT_EN to register tens_q/ones_q/ovf_q; otherwise they mirror the comb outputs.
module binary_to_bcd #(
    parameter int unsigned IN_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IN_W-1:0] binary_input,
    output logic [3:0]      tens,
    output logic [3:0]      ones,
    output logic            ovf,
    output logic [3:0]      tens_q,
    output logic [3:0]      ones_q,
    output logic            ovf_q
);

    if (IN_W < 1 || IN_W > 7) begin : g_bad_width
        $error("binary_to_bcd: IN_W must be in 1..7");
    end

    logic [6:0]  bin_ext;
    logic [11:0] scratch;
    logic [3:0]  hund_raw;
    logic [3:0]  tens_raw;
    logic [3:0]  ones_raw;

    assign bin_ext = 7'(binary_input);

    always_comb begin
        scratch = '0;
        for (int i = 6; i >= 0; i--) begin
            if (scratch[3:0] >= 4'd5) scratch[3:0] = scratch[3:0] + 4'd3;
            if (scratch[7:4] >= 4'd5) scratch[7:4] = scratch[7:4] + 4'd3;
            if (scratch[11:8] >= 4'd5) scratch[11:8] = scratch[11:8] + 4'd3;
            scratch = {scratch[10:0], bin_ext[i]};
        end
    end

    assign hund_raw = scratch[11:8];
    assign tens_raw = scratch[7:4];
    assign ones_raw = scratch[3:0];

    // Hundreds digit only feeds the overflow flag; digits saturate to 99 beyond that.
    assign ovf  = (hund_raw != 4'd0);
    assign tens = ovf ? 4'd9 : tens_raw;
    assign ones = ovf ? 4'd9 : ones_raw;

`ifdef BCD_REG_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
            ovf_q  <= 1'b0;
        end else begin
            tens_q <= tens;
            ones_q <= ones;
            ovf_q  <= ovf;
        end
    end
`else
    assign tens_q = tens;
    assign ones_q = ones;
    assign ovf_q  = ovf;
`endif

endmodule

// File: tb/tb_binary_to_bcd.sv
// Self-checking bench for binary_to_bcd: IN_W=5 and IN_W=7 instances, table vectors,
// exhaustive sweep, and registered-path sequences for either build of BCD_REG_OUT_EN.
module tb_binary_to_bcd;

    logic       clk;
    logic       clk_run;
    logic       rst_n;
    logic [4:0] in5;
    logic [6:0] in7;
    logic [3:0] tens5, ones5, tens5_q, ones5_q;
    logic [3:0] tens7, ones7, tens7_q, ones7_q;
    logic       ovf5, ovf5_q, ovf7, ovf7_q;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0] t;
        logic [3:0] o;
        logic       v;
    } exp_t;

    typedef struct {
        bit          wide;
        int unsigned val;
        logic [3:0]  t;
        logic [3:0]  o;
        logic        v;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[9];

    binary_to_bcd #(.IN_W(5)) u_dut5 (
        .clk          (clk),
        .rst_n        (rst_n),
        .binary_input (in5),
        .tens         (tens5),
        .ones         (ones5),
        .ovf          (ovf5),
        .tens_q       (tens5_q),
        .ones_q       (ones5_q),
        .ovf_q        (ovf5_q)
    );

    binary_to_bcd #(.IN_W(7)) u_dut7 (
        .clk          (clk),
        .rst_n        (rst_n),
        .binary_input (in7),
        .tens         (tens7),
        .ones         (ones7),
        .ovf          (ovf7),
        .tens_q       (tens7_q),
        .ones_q       (ones7_q),
        .ovf_q        (ovf7_q)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got tens/ones/ovf=%h/%h/%b, expected %h/%h/%b", name,
                     act[8:5], act[4:1], act[0], exp[8:5], exp[4:1], exp[0]);
        end
    endtask

    task automatic sb_push(input logic [3:0] t, input logic [3:0] o, input logic v);
        exp_t e;
        e.t = t;
        e.o = o;
        e.v = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input string name, input logic [8:0] act);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %h", name, act);
        end else begin
            e = sb_q.pop_front();
            check(name, act, {e.t, e.o, e.v});
        end
    endtask

    task automatic wait_posedge(input string name);
        bit seen;
        seen = 0;
        fork
            begin @(posedge clk); seen = 1; end
            #100;
        join_any
        disable fork;
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: clock edge timeout, got none expected posedge", name);
        end
    endtask

    initial begin
        vecs[0] = '{0, 9,   4'd0, 4'd9, 1'b0};
        vecs[1] = '{0, 10,  4'd1, 4'd0, 1'b0};
        vecs[2] = '{0, 20,  4'd2, 4'd0, 1'b0};
        vecs[3] = '{0, 29,  4'd2, 4'd9, 1'b0};
        vecs[4] = '{0, 30,  4'd3, 4'd0, 1'b0};
        vecs[5] = '{1, 99,  4'd9, 4'd9, 1'b0};
        vecs[6] = '{1, 100, 4'd9, 4'd9, 1'b1};
        vecs[7] = '{1, 127, 4'd9, 4'd9, 1'b1};
        vecs[8] = '{1, 0,   4'd0, 4'd0, 1'b0};

        clk     = 0;
        clk_run = 0;
        rst_n   = 0;
        in5     = '0;
        in7     = '0;
        #10;
        check("reset_q5", {tens5_q, ones5_q, ovf5_q}, 9'h0);
        check("reset_q7", {tens7_q, ones7_q, ovf7_q}, 9'h0);

        // Exhaustive IN_W=5 sweep, clock stopped.
        for (int n = 0; n < 32; n++) begin
            in5 = 5'(n);
            sb_push(4'(n / 10), 4'(n % 10), 1'b0);
            #10;
            sb_check($sformatf("sweep_%0d", n), {tens5, ones5, ovf5});
        end

        // Digit boundaries and overflow table.
        for (int i = 0; i < 9; i++) begin
            logic [8:0] act;
            if (vecs[i].wide) in7 = 7'(vecs[i].val);
            else              in5 = 5'(vecs[i].val);
            sb_push(vecs[i].t, vecs[i].o, vecs[i].v);
            #10;
            act = vecs[i].wide ? {tens7, ones7, ovf7} : {tens5, ones5, ovf5};
            sb_check($sformatf("table_%0d", vecs[i].val), act);
        end

`ifdef BCD_REG_OUT_EN
        rst_n = 0;
        in5   = 5'd27;
        in7   = 7'd120;
        #10;
        check("held_reset_q", {tens5_q, ones5_q, ovf5_q}, 9'h0);
        rst_n   = 1;
        #2;
        check("released_no_edge", {tens5_q, ones5_q, ovf5_q}, 9'h0);
        clk_run = 1;
        sb_push(4'd2, 4'd7, 1'b0);
        wait_posedge("edge1");
        #1;
        sb_check("lat_27", {tens5_q, ones5_q, ovf5_q});
        check("ovf_q_120", {tens7_q, ones7_q, ovf7_q}, {4'd9, 4'd9, 1'b1});
        in5 = 5'd13;
        #1;
        check("before_edge_13", {tens5_q, ones5_q, ovf5_q}, {4'd2, 4'd7, 1'b0});
        sb_push(4'd1, 4'd3, 1'b0);
        wait_posedge("edge2");
        #1;
        sb_check("lat_13", {tens5_q, ones5_q, ovf5_q});
        in5 = 5'd27;
        sb_push(4'd2, 4'd7, 1'b0);
        wait_posedge("edge3");
        #1;
        sb_check("reload_27", {tens5_q, ones5_q, ovf5_q});
        #1;
        rst_n = 0;
        #1;
        check("async_rst_q5", {tens5_q, ones5_q, ovf5_q}, 9'h0);
        check("async_rst_q7", {tens7_q, ones7_q, ovf7_q}, 9'h0);
        check("async_rst_comb", {tens5, ones5, ovf5}, {4'd2, 4'd7, 1'b0});
        clk_run = 0;
`else
        rst_n = 1;
        in5   = 5'd25;
        sb_push(4'd2, 4'd5, 1'b0);
        #1;
        sb_check("passthru_25", {tens5_q, ones5_q, ovf5_q});
        in7   = 7'd110;
        #1;
        check("passthru_ovf", {tens7_q, ones7_q, ovf7_q}, {4'd9, 4'd9, 1'b1});
        rst_n = 0;
        #1;
        check("passthru_rst", {tens5_q, ones5_q, ovf5_q}, {4'd2, 4'd5, 1'b0});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/binary_to_bcd.md
Name: binary_to_bcd

Overview:
- Converts an unsigned binary value of up to 7 bits into two BCD digits, tens and ones.
- The primary tens/ones outputs are purely combinational, with zero latency from binary_input.
- A clocked copy of the result (tens_q/ones_q/ovf_q) is provided for downstream synchronous logic, e.g. 7-segment or display drivers.
- Conversion uses the shift-add-3 (double-dabble) algorithm, unrolled combinationally.

Parameters:
- IN_W, 5, width of binary_input; legal range 1..7; elaboration error outside this range.

Ports:
- clk  input  1  system clock; rising edge used.
- rst_n  input  1  asynchronous active-low reset; affects registered outputs only.
- binary_input  input  IN_W  unsigned binary value to convert.
- tens  output  4  combinational BCD tens digit (0..9).
- ones  output  4  combinational BCD ones digit (0..9).
- ovf  output  1  combinational overflow flag; 1 when binary_input > 99.
- tens_q  output  4  registered tens digit.
- ones_q  output  4  registered ones digit.
- ovf_q  output  1  registered overflow flag.

Behaviour:
- Combinational path: tens = binary_input / 10 and ones = binary_input % 10 when binary_input <= 99.
  - Depends only on binary_input; no dependency on clk or rst_n.
  - Must settle within one evaluation; no latches.
- Input width handling: binary_input is zero-extended to 7 bits internally.
  - For IN_W <= 6, ovf is constant 0.
- Overflow (IN_W = 7 only): binary_input in 100..127 gives ovf = 1 and saturated digits tens = 9, ones = 9.
- Digits are always valid BCD; 4'hA..4'hF never appear on tens/ones/tens_q/ones_q.
- Algorithm: double-dabble over 7 input bits with a 3-digit internal BCD scratch.
  - At each shift, any digit >= 5 is incremented by 3 before the shift.
  - The hundreds digit is used only to derive ovf.
- Registered path: on each rising clk edge, tens_q/ones_q/ovf_q <= tens/ones/ovf.
  - Latency is exactly 1 cycle from a stable binary_input.
- Reset: while rst_n = 0, tens_q = 0, ones_q = 0, ovf_q = 0, applied asynchronously (immediately, not on a clock edge).
  - Release is synchronous to the next rising clk; the first capture occurs on the first edge after rst_n = 1.
- Reset mid-operation: combinational outputs remain valid and unaffected; registered outputs clear immediately.
- Input X/Z: no requirement; outputs may be X.

Optional Feature:
- Macro: BCD_REG_OUT_EN.
- Defined: the registered path is as described above (1-cycle latency, async reset to 0).
- Undefined: no flops are instantiated.
  - tens_q/ones_q/ovf_q are continuously assigned from tens/ones/ovf (zero latency).
  - clk and rst_n are left unused.
- The combinational tens/ones/ovf behaviour is identical in both builds.

Test Plan:
- Exhaustive sweep, IN_W = 5: binary_input = 0..31, 10 ns settle after each, no clock edges -> tens = n/10 and ones = n%10 for every value, e.g. 0 -> 0/0, 9 -> 0/9, 10 -> 1/0, 19 -> 1/9, 31 -> 3/1; ovf = 0 throughout.
- Digit boundaries: 9 -> 10 -> 20 -> 29 -> 30 -> tens/ones = 0/9, 1/0, 2/0, 2/9, 3/0; no digit ever exceeds 9.
- Overflow, IN_W = 7:
  - 99 -> 9/9 with ovf = 0.
  - 100 -> 9/9 with ovf = 1.
  - 127 -> 9/9 with ovf = 1.
  - 0 -> 0/0 with ovf = 0.
- Registered latency (BCD_REG_OUT_EN defined): rst_n low then released, binary_input = 27 -> tens_q/ones_q = 0/0 until the first rising edge, then 2/7; input changed to 13 -> tens_q/ones_q = 1/3 one edge later.
- Async reset: with tens_q/ones_q = 2/7, drop rst_n between clock edges -> tens_q/ones_q/ovf_q = 0 immediately, without waiting for clk; tens/ones still 2/7.
- Macro undefined: binary_input = 25 with clk held static -> tens_q/ones_q = 2/5 with zero latency.
